// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from fifo_sync and sends each one as a UART frame.
// The frame is a start bit, then the data bits LSB first, then an optional even
// parity bit, then a stop bit. A pop in the last stop cycle starts the next frame
// with no idle gap between the two frames.
module fifo_uart_tx #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0]  BitMax  = BitW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                state_q, state_d;
    logic [BaudW-1:0]      baud_cnt_q, baud_cnt_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  baud_tc;
    logic                  last_stop;
    logic                  pop;

    assign baud_tc   = (baud_cnt_q == BaudMax);
    assign last_stop = (state_q == StStop) && baud_tc;
    // Gated with reset_b so that no pop is requested while the block is held in reset.
    assign pop       = reset_b & enable & ~fifo_empty & ((state_q == StIdle) | last_stop);

    assign fifo_rd_en = pop;
    assign tx         = tx_q;
    assign busy       = (state_q != StIdle);
    assign done       = last_stop;

    // Next-state logic: bit sequencing, word capture on pop, and the next tx level.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tx_d       = 1'b1;

        if (state_q != StIdle) begin
            baud_cnt_d = baud_tc ? '0 : baud_cnt_q + 1'b1;
        end

        case (state_q)
            StStart: begin
                if (baud_tc) state_d = StData;
            end
            StData: begin
                if (baud_tc) begin
                    if (bit_cnt_q == BitMax) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            StParity: begin
                if (baud_tc) state_d = StStop;
            end
            StStop: begin
                if (baud_tc) state_d = StIdle;
            end
            default: begin
                state_d = state_q;
            end
        endcase

        // A pop overrides the return to idle so back-to-back frames stay seamless.
        if (pop) begin
            state_d    = StStart;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            shift_d    = fifo_data;
            parity_d   = ^fifo_data;
        end

        // tx is registered, so drive the level that belongs to the next state.
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset aborts any frame and returns tx to idle.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: instance 0 without parity, instance 1 with even parity,
// both at 4 clocks per bit. Expected frames are queued when words are written to
// the FIFO model; a negedge monitor decodes tx and checks pop/done timing.
module tb_fifo_uart_tx;

    localparam int Cpb = 4;

    logic       clk = 1'b0;
    logic       reset_b;
    logic [1:0] en;
    logic [1:0] fifo_empty;
    logic [7:0] fdat [2];
    logic [1:0] rd_w, tx_w, busy_w, done_w;

    logic [7:0] mem [2][64];
    int         wr_p [2] = '{0, 0};
    int         rd_p [2] = '{0, 0};
    int         cyc = 0;

    logic [15:0] exp_q0[$], exp_q1[$];
    int          pq0[$], pq1[$];
    bit          rx_act [2] = '{0, 0};
    int          rx_cnt [2] = '{0, 0};
    logic [15:0] rx_bits [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(Cpb), .PARITY_EN(0)) dut (
        .clk(clk), .reset_b(reset_b), .enable(en[0]), .fifo_empty(fifo_empty[0]),
        .fifo_data(fdat[0]), .fifo_rd_en(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]),
        .done(done_w[0])
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(Cpb), .PARITY_EN(1)) dut_p (
        .clk(clk), .reset_b(reset_b), .enable(en[1]), .fifo_empty(fifo_empty[1]),
        .fifo_data(fdat[1]), .fifo_rd_en(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]),
        .done(done_w[1])
    );

    // FIFO models: head word and empty flag follow the pointers.
    assign fifo_empty[0] = (wr_p[0] == rd_p[0]);
    assign fifo_empty[1] = (wr_p[1] == rd_p[1]);
    assign fdat[0]       = mem[0][rd_p[0]];
    assign fdat[1]       = mem[1][rd_p[1]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) if (rd_w[i]) rd_p[i] <= rd_p[i] + 1;
    end

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic [15:0] frame);
        mem[i][wr_p[i]] = d;
        wr_p[i]++;
        if (i == 0) exp_q0.push_back(frame);
        else        exp_q1.push_back(frame);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd(input int i, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rd_w[i] && n < budget);
        chk("wait_pop_timeout", int'(rd_w[i]), 1);
    endtask

    task automatic wait_idle(input int i, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_w[i] && n < budget);
        chk("wait_idle_timeout", int'(busy_w[i]), 0);
    endtask

    // Per-instance monitor: pop/done latency scoreboard and mid-bit frame decode.
    task automatic mon(input int i);
        int          idx;
        int          p;
        int          nbits;
        logic [15:0] e;
        nbits = (i == 0) ? 10 : 11;
        if (!reset_b) begin
            rx_act[i] = 0;
            if (i == 0) pq0.delete();
            else        pq1.delete();
            return;
        end
        if (rd_w[i]) begin
            chk("pop_while_empty", int'(fifo_empty[i]), 0);
            if (i == 0) pq0.push_back(cyc);
            else        pq1.push_back(cyc);
        end
        if (done_w[i]) begin
            if ((i == 0 && pq0.size() == 0) || (i == 1 && pq1.size() == 0)) begin
                chk("done_without_pop", 1, 0);
            end else begin
                p = (i == 0) ? pq0.pop_front() : pq1.pop_front();
                chk((i == 0) ? "done_latency0" : "done_latency1", cyc - p, nbits * Cpb);
            end
        end
        if (!rx_act[i] && tx_w[i] == 1'b0) begin
            rx_act[i]  = 1;
            rx_cnt[i]  = 0;
            rx_bits[i] = '0;
        end
        if (rx_act[i]) begin
            if (rx_cnt[i] % Cpb == Cpb / 2) begin
                idx = rx_cnt[i] / Cpb;
                rx_bits[i][idx] = tx_w[i];
                if (idx == nbits - 1) begin
                    rx_act[i] = 0;
                    if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
                        chk("unexpected_frame", int'(rx_bits[i]), 0);
                    end else begin
                        e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        chk((i == 0) ? "frame0" : "frame1", int'(rx_bits[i]), int'(e));
                    end
                end
            end
            rx_cnt[i]++;
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad;
        int c_a, c_b, n_rd, n_done;

        reset_b = 1'b0;
        en      = 2'b11;
        // 0xA5 -> start 0, 1,0,1,0,0,1,0,1, stop 1
        push(0, 8'hA5, 16'h034A);
        repeat (3) @(negedge clk);
        chk("rst_tx", int'(tx_w), 3);
        chk("rst_busy", int'(busy_w), 0);
        chk("rst_done", int'(done_w), 0);
        chk("rst_rd_en", int'(rd_w), 0);
        tick();
        reset_b = 1'b1;

        // Single frame: one-cycle pop, decode and latency checked by the monitor.
        wait_rd(0, 10);
        @(negedge clk);
        chk("rd_one_cycle", int'(rd_w[0]), 0);
        chk("start_after_pop", int'(tx_w[0]), 0);
        wait_idle(0, 100);

        // Empty FIFO with enable high: nothing moves.
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rd_w[0] || !tx_w[0] || busy_w[0] || done_w[0]) bad = 1;
        end
        chk("idle_quiet", int'(bad), 0);

        // Back-to-back 0x00 then 0xFF.
        tick();
        push(0, 8'h00, 16'h0200);
        push(0, 8'hFF, 16'h03FE);
        wait_rd(0, 10);
        c_a  = cyc;
        c_b  = 0;
        n_rd = 0;
        bad  = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (!busy_w[0]) bad = 1;
            if (rd_w[0]) begin
                n_rd++;
                c_b = cyc;
            end
            if (k == 40) chk("b2b_stop_level", int'(tx_w[0]), 1);
            if (k == 41) chk("b2b_start_level", int'(tx_w[0]), 0);
        end
        chk("b2b_busy_held", int'(bad), 0);
        chk("b2b_second_pop", n_rd, 1);
        chk("b2b_pop_spacing", c_b - c_a, 40);
        @(negedge clk);
        chk("b2b_busy_drop", int'(busy_w[0]), 0);

        // Parity instance: 0x07 (parity 1) then 0x03 (parity 0).
        tick();
        push(1, 8'h07, 16'h060E);
        push(1, 8'h03, 16'h0406);
        wait_rd(1, 10);
        wait_idle(1, 200);

        // Reset during data bit 3; the captured word is dropped, the next is sent.
        tick();
        push(0, 8'h3C, 16'h0278);
        push(0, 8'h81, 16'h0302);
        wait_rd(0, 10);
        repeat (18) @(posedge clk);
        #1;
        chk("busy_before_reset", int'(busy_w[0]), 1);
        reset_b = 1'b0;
        void'(exp_q0.pop_front());
        #1;
        chk("async_rst_tx", int'(tx_w[0]), 1);
        chk("async_rst_busy", int'(busy_w[0]), 0);
        repeat (2) tick();
        reset_b = 1'b1;
        wait_rd(0, 10);
        wait_idle(0, 100);
        chk("after_reset_drained", rd_p[0], wr_p[0]);

        // enable drops mid-frame with three words queued.
        tick();
        push(0, 8'h11, 16'h0222);
        push(0, 8'h22, 16'h0244);
        push(0, 8'h33, 16'h0266);
        wait_rd(0, 10);
        repeat (12) tick();
        en[0]  = 1'b0;
        n_rd   = 0;
        n_done = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (rd_w[0]) n_rd++;
            if (done_w[0]) n_done++;
        end
        chk("en_off_no_pop", n_rd, 0);
        chk("en_off_one_done", n_done, 1);
        chk("en_off_busy", int'(busy_w[0]), 0);
        tick();
        en[0] = 1'b1;
        wait_rd(0, 10);
        wait_idle(0, 200);
        chk("en_on_drained", rd_p[0], wr_p[0]);

        repeat (5) @(negedge clk);
        chk("frames_left0", exp_q0.size(), 0);
        chk("frames_left1", exp_q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
